channel_split: RTL and testbench
================================

// Module: channel_split
// PURPOSE
//  Decoder-side counterpart of the Y/Cb/Cr merger: accepts the tagged 32-bit JPEG word stream
//  (data_valid 1=Y, 2=Cb, 3=Cr, 0=idle) and demultiplexes each word into a per-channel FIFO.
//  Each channel is drained independently through a show-ahead valid/read interface.
//  Per-channel fill levels, word counts and sticky overflow flags are provided for monitoring.
// PARAMETERS
//  DEPTH   16  entries per channel FIFO; power of 2, >= 2
//  AW      4   log2(DEPTH); pointer width
//  CNT_W   16  width of per-channel accepted-word counters (saturating)
// PORTS
//  clk             in   1      single clock; all logic on posedge
//  img_rst         in   1      synchronous, active-high reset
//  jpeg_bitstream  in   32     incoming word, sampled when data_valid != 0
//  data_valid      in   2      channel tag: 0 idle, 1 Y, 2 Cb, 3 Cr
//  y_rd/cb_rd/cr_rd in  1 ea   pop request; effective only while matching *_valid = 1
//  y_jpeg/cb_jpeg/cr_jpeg out 32 ea  head word of channel FIFO (show-ahead)
//  y_valid/cb_valid/cr_valid out 1 ea  channel FIFO non-empty
//  y_level/cb_level/cr_level out AW+1 ea  current occupancy, 0..DEPTH
//  y_cnt/cb_cnt/cr_cnt out CNT_W ea  words accepted since reset, saturates at all-ones
//  y_ovf/cb_ovf/cr_ovf out 1 ea  sticky: a word for that channel was dropped
// BEHAVIOUR
//  - Reset (img_rst=1 at posedge): pointers, levels, counts, ovf cleared; *_valid=0, *_level=0,
//    *_cnt=0, *_ovf=0 from the following cycle. Reset overrides any push/pop in that cycle.
//    *_jpeg is don't-care while *_valid=0 (bench must not check it).
//  - Push: data_valid=N (1..3) pushes jpeg_bitstream into channel N only; other channels untouched.
//    Exactly one channel written per cycle; data_valid=0 writes nothing.
//  - Latency: word pushed at edge k is visible on *_jpeg with *_valid=1 after edge k (cycle k+1)
//    if FIFO was empty; otherwise in strict FIFO order behind earlier words.
//  - Pop: at posedge with *_valid=1 and *_rd=1, head advances; *_rd while *_valid=0 is ignored.
//  - Levels: level' = level + push_ok - pop_ok, per channel, registered.
//  - Full (level=DEPTH): push without same-cycle pop is dropped, *_ovf set (sticky until reset),
//    *_cnt not incremented. Push with same-cycle pop on full FIFO is accepted; level stays DEPTH.
//  - Empty with simultaneous push: pop ignored (valid=0), push accepted, level 0->1.
//  - Pointers are AW bits and wrap DEPTH-1 -> 0; full/empty resolved by level, not pointer compare.
//  - *_cnt increments on each accepted push; holds at 2^CNT_W-1 (no wrap).
//  - No backpressure upstream: producer is free-running; overflow is a reported error only.
//  - No combinational path from data_valid/jpeg_bitstream to any output; *_rd affects state only.
// TESTING
//  1. Reset, then tags 1,2,3,1 with words A0,B0,C0,A1 -> y gets A0 then A1, cb B0, cr C0;
//     y_level=2, cb_level=1, cr_level=1; counts 2/1/1; all ovf=0.
//  2. Push Y word at edge k into empty FIFO -> y_valid=1, y_jpeg=word in cycle k+1, not earlier.
//  3. Push DEPTH+1 Y words, no reads -> y_level=16, y_ovf=1, y_cnt=16, first 16 words read back
//     in order; cb/cr unaffected (level 0, ovf 0).
//  4. Full Y FIFO, push with y_rd=1 same cycle -> y_level stays 16, y_ovf stays 0, new word last.
//  5. Push/pop 40 words through Cr at steady 1 in/1 out -> no loss, order preserved across
//     pointer wrap, cr_level toggles 0/1, cr_cnt=40.
//  6. Assert img_rst mid-stream with data_valid=1 and y_rd=1 -> next cycle all valid=0,
//     levels=0, counts=0, ovf=0; pushed word discarded.

Source files
------------

// File: rtl/channel_split_if.sv
// Bus bundle for channel_split: tagged word input plus three show-ahead channel outputs.
interface channel_split_if #(
  parameter int unsigned AW    = 4,
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      jpeg_bitstream;
  logic [1:0]       data_valid;

  logic             y_rd;
  logic             cb_rd;
  logic             cr_rd;

  logic [31:0]      y_jpeg;
  logic [31:0]      cb_jpeg;
  logic [31:0]      cr_jpeg;
  logic             y_valid;
  logic             cb_valid;
  logic             cr_valid;
  logic [AW:0]      y_level;
  logic [AW:0]      cb_level;
  logic [AW:0]      cr_level;
  logic [CNT_W-1:0] y_cnt;
  logic [CNT_W-1:0] cb_cnt;
  logic [CNT_W-1:0] cr_cnt;
  logic             y_ovf;
  logic             cb_ovf;
  logic             cr_ovf;

  // Producer/consumer side: drives the tagged stream and the pop requests.
  modport master (
    output jpeg_bitstream, data_valid, y_rd, cb_rd, cr_rd,
    input  y_jpeg, cb_jpeg, cr_jpeg, y_valid, cb_valid, cr_valid,
    input  y_level, cb_level, cr_level, y_cnt, cb_cnt, cr_cnt,
    input  y_ovf, cb_ovf, cr_ovf
  );

  // Splitter side.
  modport slave (
    input  jpeg_bitstream, data_valid, y_rd, cb_rd, cr_rd,
    output y_jpeg, cb_jpeg, cr_jpeg, y_valid, cb_valid, cr_valid,
    output y_level, cb_level, cr_level, y_cnt, cb_cnt, cr_cnt,
    output y_ovf, cb_ovf, cr_ovf
  );
endinterface

// File: rtl/channel_split.sv
// Y/Cb/Cr demultiplexer: routes each tagged word into one of three show-ahead FIFOs
// with per-channel occupancy, accepted-word counter and sticky overflow flag.

// One channel FIFO; full/empty come from the level register, pointers simply wrap.
module channel_split_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             img_rst,
  input  logic             push,
  input  logic [31:0]      din,
  input  logic             rd,
  output logic [31:0]      dout,
  output logic             valid,
  output logic [AW:0]      level,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);
  localparam int unsigned LW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          pop_ok;
  logic          push_ok;
  logic [AW:0]   level_nxt;

  // Pop only a non-empty FIFO; a full FIFO still accepts a push when a pop frees the slot.
  always_comb begin
    full      = (level == LW'(DEPTH));
    pop_ok    = rd && valid;
    push_ok   = push && (!full || pop_ok);
    level_nxt = level;
    if (push_ok && !pop_ok) begin
      level_nxt = level + LW'(1);
    end else if (!push_ok && pop_ok) begin
      level_nxt = level - LW'(1);
    end
  end

  // Storage array; contents are meaningless while the FIFO is empty, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok && !img_rst) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers, occupancy, valid flag, saturating counter and sticky overflow.
  always_ff @(posedge clk) begin
    if (img_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      valid  <= 1'b0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level_nxt;
      valid <= (level_nxt != '0);
      if (push_ok && (cnt != {CNT_W{1'b1}})) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (push && !push_ok) begin
        ovf <= 1'b1;
      end
    end
  end

  // Show-ahead head word straight from storage.
  assign dout = mem[rd_ptr];
endmodule

// Top: decode the channel tag and fan the word out to the three channel FIFOs.
module channel_split #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned CNT_W = 16
) (
  input logic           clk,
  input logic           img_rst,
  channel_split_if.slave bus
);
  logic push_y;
  logic push_cb;
  logic push_cr;

  // One-hot channel select from the tag; tag 0 selects nothing.
  always_comb begin
    push_y  = (bus.data_valid == 2'd1);
    push_cb = (bus.data_valid == 2'd2);
    push_cr = (bus.data_valid == 2'd3);
  end

  channel_split_fifo #(.DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W)) u_y (
    .clk     (clk),
    .img_rst (img_rst),
    .push    (push_y),
    .din     (bus.jpeg_bitstream),
    .rd      (bus.y_rd),
    .dout    (bus.y_jpeg),
    .valid   (bus.y_valid),
    .level   (bus.y_level),
    .cnt     (bus.y_cnt),
    .ovf     (bus.y_ovf)
  );

  channel_split_fifo #(.DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W)) u_cb (
    .clk     (clk),
    .img_rst (img_rst),
    .push    (push_cb),
    .din     (bus.jpeg_bitstream),
    .rd      (bus.cb_rd),
    .dout    (bus.cb_jpeg),
    .valid   (bus.cb_valid),
    .level   (bus.cb_level),
    .cnt     (bus.cb_cnt),
    .ovf     (bus.cb_ovf)
  );

  channel_split_fifo #(.DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W)) u_cr (
    .clk     (clk),
    .img_rst (img_rst),
    .push    (push_cr),
    .din     (bus.jpeg_bitstream),
    .rd      (bus.cr_rd),
    .dout    (bus.cr_jpeg),
    .valid   (bus.cr_valid),
    .level   (bus.cr_level),
    .cnt     (bus.cr_cnt),
    .ovf     (bus.cr_ovf)
  );
endmodule

// File: tb/tb_channel_split.sv
// Bench for channel_split: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_channel_split;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned CNT_W = 16;

  logic clk;
  logic img_rst;
  int   total;
  int   bad;
  bit   chk_en;

  channel_split_if #(.AW(AW), .CNT_W(CNT_W)) bus ();

  channel_split #(.DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .img_rst (img_rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one queue per channel, counters and sticky flags.
  logic [31:0] mq [3][$];
  int unsigned mcnt [3];
  bit          movf [3];

  always @(posedge clk) begin
    bit r;
    bit p;
    bit pop;
    if (img_rst) begin
      for (int c = 0; c < 3; c++) begin
        mq[c].delete();
        mcnt[c] = 0;
        movf[c] = 1'b0;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        r   = (c == 0) ? bus.y_rd : (c == 1) ? bus.cb_rd : bus.cr_rd;
        p   = (bus.data_valid == 2'(c + 1));
        pop = r && (mq[c].size() != 0);
        if (pop) void'(mq[c].pop_front());
        if (p) begin
          if (mq[c].size() < DEPTH) begin
            mq[c].push_back(bus.jpeg_bitstream);
            if (mcnt[c] < 65535) mcnt[c] = mcnt[c] + 1;
          end else begin
            movf[c] = 1'b1;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_ch(input int c, input string n, input logic v, input logic [AW:0] lv,
                        input logic [CNT_W-1:0] cn, input logic o, input logic [31:0] j);
    check({n, "_valid"}, 32'(v), 32'(mq[c].size() != 0));
    check({n, "_level"}, 32'(lv), 32'(mq[c].size()));
    check({n, "_cnt"}, 32'(cn), mcnt[c]);
    check({n, "_ovf"}, 32'(o), 32'(movf[c]));
    if (mq[c].size() != 0) check({n, "_jpeg"}, j, mq[c][0]);
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk_ch(0, "y", bus.y_valid, bus.y_level, bus.y_cnt, bus.y_ovf, bus.y_jpeg);
      chk_ch(1, "cb", bus.cb_valid, bus.cb_level, bus.cb_cnt, bus.cb_ovf, bus.cb_jpeg);
      chk_ch(2, "cr", bus.cr_valid, bus.cr_level, bus.cr_cnt, bus.cr_ovf, bus.cr_jpeg);
    end
  end

  // Drive one cycle of stimulus and return at the following negedge.
  task automatic cyc(input logic [1:0] dv, input logic [31:0] w,
                     input logic yr, input logic cbr, input logic crr);
    bus.data_valid     = dv;
    bus.jpeg_bitstream = w;
    bus.y_rd           = yr;
    bus.cb_rd          = cbr;
    bus.cr_rd          = crr;
    @(negedge clk);
    bus.data_valid = 2'd0;
    bus.y_rd       = 1'b0;
    bus.cb_rd      = 1'b0;
    bus.cr_rd      = 1'b0;
  endtask

  task automatic do_reset();
    img_rst = 1'b1;
    cyc(2'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    img_rst = 1'b0;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    chk_en = 1'b0;
    img_rst = 1'b1;
    bus.data_valid = 2'd0;
    bus.jpeg_bitstream = 32'h0;
    bus.y_rd = 1'b0;
    bus.cb_rd = 1'b0;
    bus.cr_rd = 1'b0;
    repeat (2) @(negedge clk);
    img_rst = 1'b0;
    chk_en = 1'b1;
    check("reset_y_valid", 32'(bus.y_valid), 32'd0);
    check("reset_cr_level", 32'(bus.cr_level), 32'd0);

    // Routing by tag.
    cyc(2'd1, 32'hA0A0_0000, 1'b0, 1'b0, 1'b0);
    cyc(2'd2, 32'hB0B0_0000, 1'b0, 1'b0, 1'b0);
    cyc(2'd3, 32'hC0C0_0000, 1'b0, 1'b0, 1'b0);
    cyc(2'd1, 32'hA1A1_0001, 1'b0, 1'b0, 1'b0);
    check("t1_y_level", 32'(bus.y_level), 32'd2);
    check("t1_cb_level", 32'(bus.cb_level), 32'd1);
    check("t1_cr_level", 32'(bus.cr_level), 32'd1);
    check("t1_y_cnt", 32'(bus.y_cnt), 32'd2);
    check("t1_y_head", bus.y_jpeg, 32'hA0A0_0000);
    check("t1_cb_head", bus.cb_jpeg, 32'hB0B0_0000);
    check("t1_cr_head", bus.cr_jpeg, 32'hC0C0_0000);
    cyc(2'd0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("t1_y_second", bus.y_jpeg, 32'hA1A1_0001);
    cyc(2'd0, 32'h0, 1'b1, 1'b1, 1'b1);
    check("t1_drained", 32'({bus.y_valid, bus.cb_valid, bus.cr_valid}), 32'd0);
    // Read on empty is ignored.
    cyc(2'd0, 32'h0, 1'b1, 1'b1, 1'b1);
    check("t1_empty_rd", 32'(bus.y_level), 32'd0);

    // Latency into an empty FIFO, with a simultaneous (ignored) read.
    check("t2_before", 32'(bus.y_valid), 32'd0);
    cyc(2'd1, 32'h2222_2222, 1'b1, 1'b0, 1'b0);
    check("t2_valid", 32'(bus.y_valid), 32'd1);
    check("t2_jpeg", bus.y_jpeg, 32'h2222_2222);
    check("t2_level", 32'(bus.y_level), 32'd1);

    // Overflow.
    do_reset();
    for (int i = 0; i <= 16; i++) cyc(2'd1, 32'h3000 + 32'(i), 1'b0, 1'b0, 1'b0);
    check("t3_y_level", 32'(bus.y_level), 32'd16);
    check("t3_y_ovf", 32'(bus.y_ovf), 32'd1);
    check("t3_y_cnt", 32'(bus.y_cnt), 32'd16);
    check("t3_cb_level", 32'(bus.cb_level), 32'd0);
    check("t3_cr_ovf", 32'(bus.cr_ovf), 32'd0);
    for (int i = 0; i < 16; i++) begin
      check("t3_order", bus.y_jpeg, 32'h3000 + 32'(i));
      cyc(2'd0, 32'h0, 1'b1, 1'b0, 1'b0);
    end
    check("t3_empty", 32'(bus.y_valid), 32'd0);
    check("t3_ovf_sticky", 32'(bus.y_ovf), 32'd1);

    // Push with pop on a full FIFO.
    do_reset();
    for (int i = 0; i < 16; i++) cyc(2'd1, 32'h4000 + 32'(i), 1'b0, 1'b0, 1'b0);
    cyc(2'd1, 32'h4444_4444, 1'b1, 1'b0, 1'b0);
    check("t4_level", 32'(bus.y_level), 32'd16);
    check("t4_ovf", 32'(bus.y_ovf), 32'd0);
    check("t4_head", bus.y_jpeg, 32'h4001);
    for (int i = 0; i < 15; i++) cyc(2'd0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("t4_last", bus.y_jpeg, 32'h4444_4444);
    check("t4_last_lvl", 32'(bus.y_level), 32'd1);

    // Streaming through Cr across pointer wrap.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      cyc(2'd3, 32'h5000 + 32'(i), 1'b0, 1'b0, 1'b0);
      check("t5_lvl1", 32'(bus.cr_level), 32'd1);
      check("t5_word", bus.cr_jpeg, 32'h5000 + 32'(i));
      cyc(2'd0, 32'h0, 1'b0, 1'b0, 1'b1);
      check("t5_lvl0", 32'(bus.cr_level), 32'd0);
    end
    check("t5_cnt", 32'(bus.cr_cnt), 32'd40);

    // Reset mid-stream overrides push and pop.
    cyc(2'd1, 32'h6000, 1'b0, 1'b0, 1'b0);
    cyc(2'd2, 32'h6001, 1'b0, 1'b0, 1'b0);
    img_rst = 1'b1;
    cyc(2'd1, 32'h6002, 1'b1, 1'b0, 1'b0);
    img_rst = 1'b0;
    check("t6_valid", 32'({bus.y_valid, bus.cb_valid, bus.cr_valid}), 32'd0);
    check("t6_levels", 32'({bus.y_level, bus.cb_level, bus.cr_level}), 32'd0);
    check("t6_cnts", 32'(bus.y_cnt) + 32'(bus.cb_cnt) + 32'(bus.cr_cnt), 32'd0);
    check("t6_ovf", 32'({bus.y_ovf, bus.cb_ovf, bus.cr_ovf}), 32'd0);
    cyc(2'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("t6_discarded", 32'(bus.y_valid), 32'd0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
